// File: rtl/debug_host_arbiter_pkg.sv
// Shared definitions for the debug host arbiter: FSM state encoding, default
// bus widths and the debug command opcodes common with the Debugger Module.
package dbg_pkg;

    localparam int DBG_CMD_W  = 8;
    localparam int DBG_DATA_W = 32;
    localparam int DBG_ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    // Opcodes understood by the Debugger Module
    localparam logic [DBG_CMD_W-1:0] DBG_OP_NOP       = 8'h00;
    localparam logic [DBG_CMD_W-1:0] DBG_OP_HALT      = 8'h01;
    localparam logic [DBG_CMD_W-1:0] DBG_OP_RESUME    = 8'h02;
    localparam logic [DBG_CMD_W-1:0] DBG_OP_READ_REG  = 8'h03;
    localparam logic [DBG_CMD_W-1:0] DBG_OP_WRITE_REG = 8'h04;
    localparam logic [DBG_CMD_W-1:0] DBG_OP_READ_MEM  = 8'h05;
    localparam logic [DBG_CMD_W-1:0] DBG_OP_WRITE_MEM = 8'h06;

endpackage

// File: rtl/debug_host_arbiter_if.sv
// Host-side and debugger-side signal bundle of the debug host arbiter.
// The arbiter uses the slave modport; the host/debugger environment uses master.
interface debug_host_arbiter_if
    import dbg_pkg::*;
#(
    parameter int NUM_HOSTS = 2,
    parameter int CMD_W     = DBG_CMD_W,
    parameter int DATA_W    = DBG_DATA_W,
    parameter int ADDR_W    = DBG_ADDR_W
);

    logic [NUM_HOSTS-1:0]        host_req;
    logic [NUM_HOSTS*CMD_W-1:0]  host_cmd;
    logic [NUM_HOSTS*DATA_W-1:0] host_data;
    logic [NUM_HOSTS*ADDR_W-1:0] host_addr;
    logic [NUM_HOSTS-1:0]        host_grant;
    logic [NUM_HOSTS-1:0]        host_done;
    logic                        host_err;
    logic [DATA_W-1:0]           host_result;

    logic                        debug_request;
    logic [CMD_W-1:0]            debug_command;
    logic [DATA_W-1:0]           debug_data_arg;
    logic [ADDR_W-1:0]           debug_addr_arg;
    logic                        debugger_busy;
    logic [DATA_W-1:0]           debug_result;

    modport slave (
        input  host_req, host_cmd, host_data, host_addr,
        input  debugger_busy, debug_result,
        output host_grant, host_done, host_err, host_result,
        output debug_request, debug_command, debug_data_arg, debug_addr_arg
    );

    modport master (
        output host_req, host_cmd, host_data, host_addr,
        output debugger_busy, debug_result,
        input  host_grant, host_done, host_err, host_result,
        input  debug_request, debug_command, debug_data_arg, debug_addr_arg
    );

endinterface

// File: rtl/debug_host_arbiter_rr_arbiter.sv
// Combinational round-robin picker: selects the first requester at or after
// i_ptr, wrapping around, and reports it both one-hot and encoded.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    function automatic int wrap_idx(input int base, input int offs);
        return (base + offs) % N;
    endfunction

    // Scan from the pointer; the first hit blocks all later candidates
    always_comb begin
        int   w_j;
        logic w_hit;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        w_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_j          = wrap_idx(int'(i_ptr), k);
            w_hit        = !o_any && i_req[w_j];
            o_grant[w_j] = w_hit;
            o_idx        = w_hit ? IDX_W'(w_j) : o_idx;
            o_any        = o_any | w_hit;
        end
    end

endmodule

// File: rtl/debug_host_arbiter.sv
// Shares one Debugger Module between NUM_HOSTS hosts: round-robin grant, one
// command issue, busy tracking, watchdog abort and result return per grant.
module debug_host_arbiter
    import dbg_pkg::*;
#(
    parameter int NUM_HOSTS = 2,
    parameter int CMD_W     = DBG_CMD_W,
    parameter int DATA_W    = DBG_DATA_W,
    parameter int ADDR_W    = DBG_ADDR_W,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    debug_host_arbiter_if.slave    io_bus
);

    localparam int PTR_W = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_HOSTS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic [NUM_HOSTS-1:0]  w_arb_grant;
    logic [PTR_W-1:0]      w_arb_idx;
    logic                  w_arb_any;
    logic                  w_start;
    logic                  w_finish;
    logic                  w_fail;
    logic                  w_tmr_expired;

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      r_grant_idx;
    logic [NUM_HOSTS-1:0]  r_grant;
    logic [NUM_HOSTS-1:0]  r_done;
    logic                  r_err;
    logic [DATA_W-1:0]     r_result;
    logic                  r_request;
    logic [CMD_W-1:0]      r_cmd;
    logic [DATA_W-1:0]     r_data;
    logic [ADDR_W-1:0]     r_addr;
    logic [TMR_W-1:0]      r_timer;

    rr_arbiter #(.N(NUM_HOSTS), .IDX_W(PTR_W)) u_rr_arbiter (
        .i_req   (io_bus.host_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // The timer saturates past TMR_LAST so a late exit can never wrap it
    assign w_tmr_expired = (r_timer >= TMR_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a real exit condition always beats watchdog expiry
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any && !io_bus.debugger_busy) begin
                    w_state_next = ST_ISSUE;
                    w_start      = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (io_bus.debugger_busy) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (w_tmr_expired) begin
                    w_state_next = ST_RESPOND;
                    w_finish     = 1'b1;
                    w_fail       = 1'b1;
                end else begin
                    w_state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!io_bus.debugger_busy) begin
                    w_state_next = ST_RESPOND;
                    w_finish     = 1'b1;
                end else if (w_tmr_expired) begin
                    w_state_next = ST_RESPOND;
                    w_finish     = 1'b1;
                    w_fail       = 1'b1;
                end else begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_RESPOND: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Grant ownership and round-robin pointer advance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else if (w_start) begin
            r_grant     <= w_arb_grant;
            r_grant_idx <= w_arb_idx;
        end else if (r_state == ST_RESPOND) begin
            r_grant  <= '0;
            r_rr_ptr <= (r_grant_idx == PTR_LAST) ? '0 : (r_grant_idx + PTR_ONE);
        end else begin
            r_grant <= r_grant;
        end
    end

    // Private copy of the winner's arguments, immune to later host changes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd  <= '0;
            r_data <= '0;
            r_addr <= '0;
        end else if (w_start) begin
            r_cmd  <= io_bus.host_cmd[w_arb_idx*CMD_W +: CMD_W];
            r_data <= io_bus.host_data[w_arb_idx*DATA_W +: DATA_W];
            r_addr <= io_bus.host_addr[w_arb_idx*ADDR_W +: ADDR_W];
        end else begin
            r_cmd <= r_cmd;
        end
    end

    // Watchdog timer, cleared while the request pulse is out
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_timer <= '0;
        end else if ((r_state == ST_WAIT_BUSY || r_state == ST_WAIT_DONE) && (r_timer < TMR_MAX)) begin
            r_timer <= r_timer + TMR_ONE;
        end else begin
            r_timer <= r_timer;
        end
    end

    // Request pulse lines up with the ISSUE state; completion with RESPOND
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_request <= 1'b0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_result  <= '0;
        end else begin
            r_request <= w_start;
            r_done    <= w_finish ? r_grant : '0;
            if (w_finish) begin
                r_err    <= w_fail;
                r_result <= w_fail ? '0 : io_bus.debug_result;
            end else begin
                r_err    <= r_err;
                r_result <= r_result;
            end
        end
    end

    assign io_bus.host_grant     = r_grant;
    assign io_bus.host_done      = r_done;
    assign io_bus.host_err       = r_err;
    assign io_bus.host_result    = r_result;
    assign io_bus.debug_request  = r_request;
    assign io_bus.debug_command  = r_cmd;
    assign io_bus.debug_data_arg = r_data;
    assign io_bus.debug_addr_arg = r_addr;

endmodule

// File: tb/tb_debug_host_arbiter.sv
// Scoreboard bench for debug_host_arbiter: a behavioural debugger plus a done
// monitor popping expected responses pushed by the directed stimulus.
module tb_debug_host_arbiter;
    import dbg_pkg::*;

    localparam int NH = 2;
    localparam int CW = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    typedef struct { logic [NH-1:0] done; logic err; logic [DW-1:0] result; } rsp_t;
    typedef struct { logic [CW-1:0] cmd; logic [DW-1:0] data; logic [AW-1:0] addr; } arg_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_host_arbiter_if #(.NUM_HOSTS(NH), .CMD_W(CW), .DATA_W(DW), .ADDR_W(AW)) bus ();

    debug_host_arbiter #(.NUM_HOSTS(NH), .CMD_W(CW), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    logic          m_busy   = 1'b0;
    logic          f_busy   = 1'b0;
    logic [DW-1:0] m_result = '0;
    assign bus.debugger_busy = m_busy | f_busy;
    assign bus.debug_result  = m_result;

    rsp_t exp_q[$];
    arg_t arg_q[$];
    int errors = 0, checks = 0;
    int done_count = 0, req_count = 0, cyc = 0;
    int last_done_cyc = 0, last_req_cyc = 0;
    bit model_never = 1'b0, model_echo = 1'b0;
    logic [DW-1:0] model_result = 32'h0000_1234;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_host(input int h, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [AW-1:0] a);
        bus.host_cmd[h*CW +: CW]  = c;
        bus.host_data[h*DW +: DW] = d;
        bus.host_addr[h*AW +: AW] = a;
    endtask

    // Queue one command: arguments the debugger must see, response the host must get
    task automatic expect_cmd(input int h, input logic [CW-1:0] c, input logic [DW-1:0] d,
                              input logic [AW-1:0] a, input logic err, input logic [DW-1:0] res);
        arg_t ea;
        rsp_t er;
        ea.cmd = c; ea.data = d; ea.addr = a;
        er.done = NH'(1) << h; er.err = err; er.result = res;
        arg_q.push_back(ea);
        exp_q.push_back(er);
        set_host(h, c, d, a);
    endtask

    task automatic wait_done(input int target);
        int budget = 200;
        while (done_count < target && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("done_wait", 64'(done_count >= target), 64'd1);
    endtask

    task automatic wait_busy();
        int budget = 50;
        while (!m_busy && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("busy_wait", 64'(m_busy), 64'd1);
    endtask

    task automatic wait_grant();
        int budget = 50;
        while (bus.host_grant == '0 && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("grant_wait", 64'(bus.host_grant != '0), 64'd1);
    endtask

    // Behavioural debugger: busy 3 cycles after request, idle 10 cycles later
    initial begin : debugger_model
        arg_t a;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (rst_n && bus.debug_request) begin
                if (arg_q.size() == 0) begin
                    chk("arg_queue_empty", 64'd1, 64'd0);
                end else begin
                    a = arg_q.pop_front();
                    chk("issue_cmd", 64'(bus.debug_command), 64'(a.cmd));
                    chk("issue_data", 64'(bus.debug_data_arg), 64'(a.data));
                    chk("issue_addr", 64'(bus.debug_addr_arg), 64'(a.addr));
                    if (!model_never) begin
                        aborted = 1'b0;
                        for (int k = 0; k < 3; k++) begin
                            @(negedge clk);
                            if (!rst_n) begin aborted = 1'b1; break; end
                        end
                        if (!aborted) begin
                            m_busy = 1'b1;
                            for (int k = 0; k < 10; k++) begin
                                @(negedge clk);
                                if (!rst_n) begin aborted = 1'b1; break; end
                            end
                        end
                        if (!aborted) begin
                            chk("held_cmd", 64'(bus.debug_command), 64'(a.cmd));
                            chk("held_data", 64'(bus.debug_data_arg), 64'(a.data));
                            chk("held_addr", 64'(bus.debug_addr_arg), 64'(a.addr));
                            m_result = model_echo ? (a.data + 32'd1) : model_result;
                        end
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: grant exclusivity, single-cycle request, scoreboard on host_done
    initial begin : monitor
        rsp_t e;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                chk("grant_onehot0", 64'($onehot0(bus.host_grant)), 64'd1);
                if (bus.debug_request) begin
                    req_count++;
                    last_req_cyc = cyc;
                    chk("request_pulse_width", 64'(prev_req), 64'd0);
                end
                prev_req = bus.debug_request;
                if (bus.host_done != '0) begin
                    done_count++;
                    last_done_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(bus.host_done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_host", 64'(bus.host_done), 64'(e.done));
                        chk("done_err", 64'(bus.host_err), 64'(e.err));
                        chk("done_result", 64'(bus.host_result), 64'(e.result));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_grant"}, 64'(bus.host_grant), 64'd0);
        chk({tag, "_done"}, 64'(bus.host_done), 64'd0);
        chk({tag, "_err"}, 64'(bus.host_err), 64'd0);
        chk({tag, "_result"}, 64'(bus.host_result), 64'd0);
        chk({tag, "_request"}, 64'(bus.debug_request), 64'd0);
        chk({tag, "_command"}, 64'(bus.debug_command), 64'd0);
        chk({tag, "_data"}, 64'(bus.debug_data_arg), 64'd0);
        chk({tag, "_addr"}, 64'(bus.debug_addr_arg), 64'd0);
    endtask

    initial begin : stimulus
        int n0;
        bus.host_req  = '0;
        bus.host_cmd  = '0;
        bus.host_data = '0;
        bus.host_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");

        // Contention straight out of reset: 0,1,0,1 from rr_ptr=0
        @(negedge clk);
        rst_n = 1'b1;
        model_echo = 1'b1;
        expect_cmd(0, 8'h11, 32'h0000_1111, 32'h200, 1'b0, 32'h0000_1112);
        expect_cmd(1, 8'h22, 32'h0000_2222, 32'h300, 1'b0, 32'h0000_2223);
        expect_cmd(0, 8'h11, 32'h0000_1111, 32'h200, 1'b0, 32'h0000_1112);
        expect_cmd(1, 8'h22, 32'h0000_2222, 32'h300, 1'b0, 32'h0000_2223);
        bus.host_req = 2'b11;
        wait_done(4);
        bus.host_req = 2'b00;

        // Single host; arguments altered after grant must not leak through
        model_echo   = 1'b0;
        model_result = 32'h0000_1234;
        n0 = req_count;
        @(negedge clk);
        expect_cmd(0, DBG_OP_READ_MEM, 32'hA5A5_0000, 32'h100, 1'b0, 32'h0000_1234);
        bus.host_req = 2'b01;
        wait_grant();
        set_host(0, 8'hFF, 32'hDEAD_BEEF, 32'hFFF);
        wait_done(5);
        bus.host_req = 2'b00;
        chk("single_request_count", 64'(req_count - n0), 64'd1);
        chk("single_latency", 64'(last_done_cyc - last_req_cyc), 64'd14);
        repeat (3) @(negedge clk);
        #1;
        chk("result_hold", 64'(bus.host_result), 64'h1234);

        // Debugger busy before the request: issue must wait for busy low
        model_result = 32'h0000_BEEF;
        n0 = req_count;
        expect_cmd(0, DBG_OP_HALT, 32'h0000_0042, 32'h104, 1'b0, 32'h0000_BEEF);
        f_busy = 1'b1;
        bus.host_req = 2'b01;
        repeat (6) @(negedge clk);
        #1;
        chk("no_issue_while_busy", 64'(req_count - n0), 64'd0);
        f_busy = 1'b0;
        wait_done(6);
        bus.host_req = 2'b00;
        chk("issue_after_busy", 64'(req_count - n0), 64'd1);

        // Watchdog: debugger never answers
        model_never = 1'b1;
        @(negedge clk);
        expect_cmd(0, DBG_OP_READ_REG, 32'h0000_0007, 32'h108, 1'b1, 32'h0);
        bus.host_req = 2'b01;
        wait_done(7);
        bus.host_req = 2'b00;
        model_never = 1'b0;
        chk("timeout_latency", 64'(last_done_cyc - last_req_cyc), 64'd17);
        repeat (3) @(negedge clk);
        #1;
        chk("timeout_err_hold", 64'(bus.host_err), 64'd1);
        chk("timeout_result_hold", 64'(bus.host_result), 64'd0);

        // Host 1 drops its request mid-command; completion still delivered
        model_result = 32'h0000_5555;
        expect_cmd(1, DBG_OP_WRITE_MEM, 32'h0000_3333, 32'h400, 1'b0, 32'h0000_5555);
        bus.host_req = 2'b10;
        wait_busy();
        @(negedge clk);
        bus.host_req = 2'b00;
        wait_done(8);

        // rr_ptr must now be 0: host 0 wins a tie
        model_result = 32'h0000_6666;
        expect_cmd(0, DBG_OP_RESUME, 32'h0000_4444, 32'h500, 1'b0, 32'h0000_6666);
        set_host(1, 8'h77, 32'h0000_7777, 32'h504);
        bus.host_req = 2'b11;
        wait_done(9);
        bus.host_req = 2'b00;

        // Reset during WAIT_DONE of a host-1 command (rr_ptr=1)
        @(negedge clk);
        begin
            arg_t ea;
            ea.cmd = 8'h77; ea.data = 32'h0000_7777; ea.addr = 32'h504;
            arg_q.push_back(ea);
        end
        bus.host_req = 2'b11;
        wait_busy();
        chk("grant_before_reset", 64'(bus.host_grant), 64'd2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        model_echo = 1'b1;
        expect_cmd(0, 8'h08, 32'h0000_AAAA, 32'h600, 1'b0, 32'h0000_AAAB);
        expect_cmd(1, 8'h09, 32'h0000_BBBB, 32'h700, 1'b0, 32'h0000_BBBC);
        rst_n = 1'b1;
        wait_done(11);
        bus.host_req = 2'b00;

        repeat (4) @(negedge clk);
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("arg_queue_drained", 64'(arg_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
